// File: rtl/sr_drv_pkg.sv
// Shared encodings for the SR latch driver: FSM states, operation codes
// and the width of the pulse/gap counter.
package sr_drv_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PULSE_S = 3'd1,
    PULSE_R = 3'd2,
    GAP     = 3'd3,
    CHECK   = 3'd4
  } state_e;

  typedef enum logic {
    OP_RESET = 1'b0,
    OP_SET   = 1'b1
  } op_e;

  function automatic state_e pulse_state(input op_e op);
    if (op == OP_SET) begin
      return PULSE_S;
    end else begin
      return PULSE_R;
    end
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer that brings the asynchronous latch output into
// the clk domain; clears to 0 on synchronous reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an active-low NAND SR latch with fixed-width sbar/rbar pulses,
// queues one pending request and checks the latch readback afterwards.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned PULSE_W = 3,
  parameter int unsigned GAP_W   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic reset_req,
  input  logic q_fb,
  output logic sbar,
  output logic rbar,
  output logic busy,
  output logic done,
  output logic err,
  output logic q_exp,
  output logic exp_valid,
  output logic ovr
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  op_e              w_op_nxt;
  logic             r_pend_v;
  op_e              r_pend_op;
  logic             w_pend_v_nxt;
  op_e              w_pend_op_nxt;

  logic r_sbar, r_rbar, r_busy, r_done, r_err, r_q_exp, r_exp_valid, r_ovr;
  logic w_sbar_nxt, w_rbar_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic w_q_exp_nxt, w_exp_valid_nxt, w_ovr_nxt;

  logic w_q_sync;
  logic w_req;
  op_e  w_req_op;
  logic w_merged_v;
  op_e  w_merged_op;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (q_fb),
    .q     (w_q_sync)
  );

  // Reset request beats set request arriving in the same cycle.
  assign w_req       = set_req | reset_req;
  assign w_req_op    = reset_req ? OP_RESET : OP_SET;
  assign w_merged_v  = r_pend_v | w_req;
  assign w_merged_op = w_req ? w_req_op : r_pend_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_op      <= OP_RESET;
      r_pend_v  <= 1'b0;
      r_pend_op <= OP_RESET;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= (w_state_nxt != r_state) ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
      r_op      <= w_op_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_pend_op <= w_pend_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_pend_v_nxt  = r_pend_v;
    w_pend_op_nxt = r_pend_op;
    case (r_state)
      IDLE: begin
        w_pend_v_nxt = 1'b0;
        if (w_req) begin
          w_state_nxt = pulse_state(w_req_op);
          w_op_nxt    = w_req_op;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PULSE_S, PULSE_R: begin
        w_pend_v_nxt  = w_merged_v;
        w_pend_op_nxt = w_merged_op;
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = GAP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      GAP: begin
        w_pend_v_nxt  = w_merged_v;
        w_pend_op_nxt = w_merged_op;
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = CHECK;
        end else begin
          w_state_nxt = GAP;
        end
      end
      CHECK: begin
        // A request landing in CHECK joins the pending slot and is launched now.
        w_pend_v_nxt = 1'b0;
        if (w_merged_v) begin
          w_state_nxt = pulse_state(w_merged_op);
          w_op_nxt    = w_merged_op;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_pend_v_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_sbar_nxt      = (w_state_nxt != PULSE_S);
    w_rbar_nxt      = (w_state_nxt != PULSE_R);
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_done_nxt      = (w_state_nxt == CHECK);
    w_ovr_nxt       = (r_state != IDLE) & w_req & r_pend_v;
    w_err_nxt       = 1'b0;
    w_q_exp_nxt     = r_q_exp;
    w_exp_valid_nxt = r_exp_valid;
    if (w_state_nxt == CHECK) begin
      w_err_nxt       = (w_q_sync != r_op);
      w_q_exp_nxt     = r_op;
      w_exp_valid_nxt = 1'b1;
    end else begin
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sbar      <= 1'b1;
      r_rbar      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_q_exp     <= 1'b0;
      r_exp_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_sbar      <= w_sbar_nxt;
      r_rbar      <= w_rbar_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_q_exp     <= w_q_exp_nxt;
      r_exp_valid <= w_exp_valid_nxt;
      r_ovr       <= w_ovr_nxt;
    end
  end

  assign sbar      = r_sbar;
  assign rbar      = r_rbar;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign q_exp     = r_q_exp;
  assign exp_valid = r_exp_valid;
  assign ovr       = r_ovr;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural NAND SR latch.
// Observed vector order: {sbar, rbar, busy, done, err, q_exp, exp_valid, ovr}.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic reset, set_req, reset_req;
  logic sbar, rbar, busy, done, err, q_exp, exp_valid, ovr;
  logic q_lat = 1'b0;
  logic stuck = 1'b0;
  logic q_fb;
  logic [7:0] obs;
  logic [7:0] exp_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_W(3), .GAP_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .set_req   (set_req),
    .reset_req (reset_req),
    .q_fb      (q_fb),
    .sbar      (sbar),
    .rbar      (rbar),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .q_exp     (q_exp),
    .exp_valid (exp_valid),
    .ovr       (ovr)
  );

  // Behavioural NAND latch: low input wins, both high holds.
  always @(sbar, rbar) begin
    if (!sbar && rbar) q_lat = 1'b1;
    else if (sbar && !rbar) q_lat = 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_lat;
  assign obs  = {sbar, rbar, busy, done, err, q_exp, exp_valid, ovr};

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((sbar | rbar) !== 1'b1) begin
        errors++;
        $display("FAIL forbidden: sbar=%b rbar=%b required not both 0", sbar, rbar);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; set_req = 1'b0; reset_req = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = 8'b1100_0000;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_set();
    for (int c = 0; c <= 8; c++) begin
      exp_v = {!(c >= 1 && c <= 3), 1'b1, (c >= 1 && c <= 6), (c == 6), 1'b0,
               (c >= 6), (c >= 6), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL set c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0); reset_req = 1'b0;
      step();
    end
  endtask

  task automatic test_both();
    for (int c = 0; c <= 8; c++) begin
      exp_v = {1'b1, !(c >= 1 && c <= 3), (c >= 1 && c <= 6), (c == 6), 1'b0,
               (c < 6), 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL both c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0); reset_req = (c == 0);
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 14; c++) begin
      exp_v = {!(c >= 1 && c <= 3), !(c >= 7 && c <= 9), (c >= 1 && c <= 12),
               (c == 6 || c == 12), 1'b0, (c >= 6 && c < 12), 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0); reset_req = (c == 2);
      step();
    end
  endtask

  task automatic test_overwrite();
    for (int c = 0; c <= 14; c++) begin
      exp_v = {!((c >= 1 && c <= 3) || (c >= 7 && c <= 9)), 1'b1, (c >= 1 && c <= 12),
               (c == 6 || c == 12), 1'b0, (c >= 6), 1'b1, (c == 5)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL overwrite c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0 || c == 4); reset_req = (c == 2);
      step();
    end
  endtask

  task automatic test_stuck();
    do_reset();
    stuck = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      exp_v = {!(c >= 1 && c <= 3), 1'b1, (c >= 1 && c <= 6), (c == 6), (c == 6),
               (c >= 6), (c >= 6), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stuck c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0); reset_req = 1'b0;
      step();
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      exp_v = {!(c >= 1 && c <= 2), 1'b1, (c >= 1 && c <= 2), 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid c=%0d: got %b want %b", c, obs, exp_v);
      end
      set_req = (c == 0); reset_req = 1'b0; reset = (c == 2);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; set_req = 1'b0; reset_req = 1'b0;
    test_reset();
    test_set();
    test_both();
    test_back_to_back();
    test_overwrite();
    test_stuck();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
